uart_rx_ext: RTL and testbench
==============================

UART_RX_EXT -- requirements
Module: uart_rx_ext

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the width of rx_data; the legal range is 5..9.
REQ-002 SHALL have parameter PRESCALE_WIDTH, default 6, meaning the width of the prescale input.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port serial_data_in, input, 1 bit: asynchronous RX line, idle high.
REQ-006 SHALL have port prescale, input, PRESCALE_WIDTH bits: clk cycles per bit; legal values are even, 8..32.
REQ-007 SHALL have port data_length, input, 2 bits: frame data length; 00=5, 01=6, 10=7, 11=8 bits. When DATA_WIDTH=9, 11 means 9 bits.
REQ-008 SHALL have ports parity_enable and parity_type, input, 1 bit each; parity_type 0=even, 1=odd.
REQ-009 SHALL have port stop_bits, input, 1 bit: 0 = one stop bit, 1 = two stop bits.
REQ-010 SHALL have port rx_ready, input, 1 bit: the consumer accepts rx_data.
REQ-011 SHALL have port rx_valid, output, 1 bit: rx_data and the frame status are valid.
REQ-012 SHALL have port rx_data, output, DATA_WIDTH bits: received word, LSB-aligned, with unused MSBs zero.
REQ-013 SHALL have ports parity_error, frame_error and break_detect, output, 1 bit each: status of the held frame, qualified by rx_valid.
REQ-014 SHALL have port overrun_error, output, 1 bit: a one-cycle pulse when a completed frame is discarded.

Function
REQ-015 SHALL pass serial_data_in through a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-016 SHALL latch prescale, data_length, parity_enable, parity_type and stop_bits on start detection, and hold them for the whole frame.
REQ-017 SHALL run a bit-period counter from 0 to prescale-1, then wrap; the counter runs only outside IDLE.
REQ-018 SHALL take three samples per bit, at counts prescale/2-1, prescale/2 and prescale/2+1, and decide the bit by 2-of-3 majority at count prescale/2+1.
REQ-019 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP and BREAK_WAIT.
REQ-020 IDLE -> START when a 1->0 transition appears on the synchronized line; the counter starts at 0 in that cycle.
REQ-021 In START: if the decided bit is 1, the FSM SHALL return to IDLE with no output (glitch rejection); otherwise it SHALL go to DATA at counter wrap.
REQ-022 DATA SHALL shift bits LSB-first, and SHALL go to PARITY (if enabled) or STOP after the latched data length.
REQ-023 PARITY: parity_error = (XOR of data bits ^ parity bit) != parity_type.
REQ-024 STOP SHALL check one or two stop bits; frame_error SHALL be set if any decided stop bit is 0.
REQ-025 The frame SHALL commit at the decision point of the last stop bit; the FSM then goes to IDLE in the same cycle, so back-to-back frames are accepted.
REQ-026 break_detect = 1 when all data bits, the parity bit (if present) and the first stop bit are 0. After commit the FSM SHALL go to BREAK_WAIT until the synchronized line is 1, then go to IDLE.
REQ-027 On commit with rx_valid=0, or rx_valid=1 with rx_ready=1 in the same cycle, the block SHALL load rx_data and the three status flags, and assert rx_valid in the next cycle.
REQ-028 On commit with rx_valid=1 and rx_ready=0, the block SHALL discard the new frame, keep the held data unchanged, and pulse overrun_error for 1 cycle.
REQ-029 When rx_valid=1 and rx_ready=1 with no commit, rx_valid SHALL go 0 in the next cycle.
REQ-030 Held outputs SHALL remain stable while rx_valid=1 and rx_ready=0.

Reset
REQ-031 While reset=1 on a clock edge: FSM=IDLE, counter=0, synchronizer flops=1, rx_valid=0, rx_data=0, parity_error=0, frame_error=0, break_detect=0, overrun_error=0.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no commit. After release, the block SHALL wait for a fresh 1->0 edge; a line already low SHALL NOT start a frame.

Structure
REQ-033 A shared package uart_rx_pkg SHALL hold the FSM state enum, the data_length encodings, the parity-type constants and the sample-offset constants.
REQ-034 A sub-module uart_rx_bit_sampler SHALL contain the synchronizer, the bit-period counter and the majority vote. It SHALL output the decided bit, a bit-done strobe and the synchronized line.
REQ-035 uart_rx_ext SHALL contain the FSM, the shift register, the parity and stop checks, and the holding register.

Verification
REQ-036 Scenario: prescale=16, 8N1, byte 0xA5, rx_ready=1 -> rx_valid pulses with rx_data=0xA5 and all errors 0.
REQ-037 Scenario: prescale=8, 7 data bits, odd parity, two stop bits, data 0x55 with a wrong parity bit -> rx_data=0x55, parity_error=1, frame_error=0.
REQ-038 Scenario: 8N1 0x3C with the stop bit forced to 0 -> frame_error=1. Then a 0-byte with a 0 stop bit, with the line held low 40 bit-times -> break_detect=1 and no further frame until the line goes high.
REQ-039 Scenario: rx_ready=0, two frames 0x11 then 0x22 -> rx_data stays 0x11 and overrun_error pulses once. Then with rx_ready=1, rx_valid drops.
REQ-040 Scenario: a 3-cycle low glitch at prescale=16 -> no rx_valid. Also, a single-cycle inverted sample at count prescale/2 in each data bit -> correct data by majority.
REQ-041 Scenario: reset pulsed in the middle of DATA -> no rx_valid; the next full frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver: FSM states, data-length
// codes, parity-type values and majority-vote sample offsets.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK_WAIT
    } rx_state_e;

    localparam logic [1:0] DLEN_5 = 2'b00;
    localparam logic [1:0] DLEN_6 = 2'b01;
    localparam logic [1:0] DLEN_7 = 2'b10;
    localparam logic [1:0] DLEN_8 = 2'b11;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    // Sample points relative to the middle of the bit period (prescale/2).
    localparam int SAMPLE_EARLY_OFS = -1;
    localparam int SAMPLE_MID_OFS   = 0;
    localparam int SAMPLE_LATE_OFS  = 1;

    // Number of data bits for a data_length code; code 11 means 9 bits only
    // on a 9-bit build, and the result never exceeds the data width.
    function automatic logic [3:0] data_bits(input logic [1:0] dlen, input int width);
        logic [3:0] n;
        case (dlen)
            DLEN_5:  n = 4'd5;
            DLEN_6:  n = 4'd6;
            DLEN_7:  n = 4'd7;
            DLEN_8:  n = (width == 9) ? 4'd9 : 4'd8;
            default: n = 4'd8;
        endcase
        if (int'(n) > width) begin
            n = 4'(width);
        end
        return n;
    endfunction

endpackage

// File: rtl/uart_rx_bit_sampler.sv
// Line front end: 2-flop synchronizer, falling-edge detect, bit-period
// counter and 2-of-3 majority vote around the bit centre.
module uart_rx_bit_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      rxd_i,
    input  logic [PRESCALE_WIDTH-1:0] prescale_i,
    input  logic                      run_i,
    output logic                      line_o,
    output logic                      fall_o,
    output logic                      bit_o,
    output logic                      bit_done_o,
    output logic                      wrap_o
);

    logic                      sync1_q, sync2_q;
    logic [1:0]                settle_q;
    logic                      prev_q;
    logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]                samp_q;

    logic [PRESCALE_WIDTH-1:0] mid, pt_early, pt_mid, pt_late, last;

    // Sample points and terminal count for the latched prescale
    always_comb begin
        mid      = prescale_i >> 1;
        pt_early = mid + PRESCALE_WIDTH'(SAMPLE_EARLY_OFS);
        pt_mid   = mid + PRESCALE_WIDTH'(SAMPLE_MID_OFS);
        pt_late  = mid + PRESCALE_WIDTH'(SAMPLE_LATE_OFS);
        last     = prescale_i - PRESCALE_WIDTH'(1);
        if (!run_i || cnt_q == last) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + PRESCALE_WIDTH'(1);
        end
    end

    // Synchronizer, edge history, bit counter and early/mid samples.
    // prev_q only becomes 1 from a high level that actually came through the
    // synchronizer, so a line that is already low out of reset never looks
    // like a falling edge.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            settle_q <= 2'b00;
            prev_q   <= 1'b0;
            cnt_q    <= '0;
            samp_q   <= 2'b00;
        end else begin
            sync1_q  <= rxd_i;
            sync2_q  <= sync1_q;
            settle_q <= {settle_q[0], 1'b1};
            prev_q   <= settle_q[1] & sync2_q;
            cnt_q    <= cnt_d;
            if (run_i && cnt_q == pt_early) begin
                samp_q[0] <= sync2_q;
            end
            if (run_i && cnt_q == pt_mid) begin
                samp_q[1] <= sync2_q;
            end
        end
    end

    assign line_o     = sync2_q;
    assign fall_o     = prev_q & ~sync2_q;
    assign bit_o      = (samp_q[0] & samp_q[1]) | (samp_q[0] & sync2_q) | (samp_q[1] & sync2_q);
    assign bit_done_o = run_i && (cnt_q == pt_late);
    assign wrap_o     = run_i && (cnt_q == last);

endmodule

// File: rtl/uart_rx_ext.sv
// UART receiver with runtime frame format, parity/frame/break status and a
// single-entry holding register with ready/valid handoff and overrun pulse.
//
// state        | meaning
// IDLE         | waiting for a falling edge on the synchronized line
// START        | checking the start bit, rejecting glitches
// DATA         | shifting in data bits LSB-first
// PARITY       | checking the parity bit
// STOP         | checking one or two stop bits, commit on the last one
// BREAK_WAIT   | after a break frame, waiting for the line to return high
module uart_rx_ext
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      serial_data_in,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic [1:0]                data_length,
    input  logic                      parity_enable,
    input  logic                      parity_type,
    input  logic                      stop_bits,
    input  logic                      rx_ready,
    output logic                      rx_valid,
    output logic [DATA_WIDTH-1:0]     rx_data,
    output logic                      parity_error,
    output logic                      frame_error,
    output logic                      break_detect,
    output logic                      overrun_error
);

    rx_state_e                 state_q;
    logic [PRESCALE_WIDTH-1:0] prescale_q;
    logic [3:0]                nbits_q;
    logic                      par_en_q, par_type_q, stop2_q;
    logic [DATA_WIDTH-1:0]     shift_q, shift_d;
    logic [3:0]                idx_q;
    logic                      par_acc_q, zero_q, stop_idx_q;
    logic                      perr_q, ferr_q, brk_q;

    logic                      rx_valid_q, perr_out_q, ferr_out_q, brk_out_q, overrun_q;
    logic [DATA_WIDTH-1:0]     rx_data_q;

    logic line, fall, samp_bit, bit_done, wrap, run;
    logic commit, stop_ferr, stop_brk;

    assign run = (state_q != ST_IDLE);

    uart_rx_bit_sampler #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_sampler (
        .clk_i      (clk),
        .reset_i    (reset),
        .rxd_i      (serial_data_in),
        .prescale_i (prescale_q),
        .run_i      (run),
        .line_o     (line),
        .fall_o     (fall),
        .bit_o      (samp_bit),
        .bit_done_o (bit_done),
        .wrap_o     (wrap)
    );

    // Frame-level status as it stands at the current stop-bit decision
    always_comb begin
        shift_d   = shift_q | (DATA_WIDTH'(samp_bit) << idx_q);
        commit    = (state_q == ST_STOP) && bit_done && (stop_idx_q || !stop2_q);
        stop_ferr = ferr_q | ~samp_bit;
        stop_brk  = stop_idx_q ? brk_q : (zero_q & ~samp_bit);
    end

    // Receive FSM, frame checks and holding register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            prescale_q <= '0;
            nbits_q    <= 4'd8;
            par_en_q   <= 1'b0;
            par_type_q <= PARITY_EVEN;
            stop2_q    <= 1'b0;
            shift_q    <= '0;
            idx_q      <= '0;
            par_acc_q  <= 1'b0;
            zero_q     <= 1'b1;
            stop_idx_q <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            brk_q      <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            brk_out_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (rx_valid_q && rx_ready && !commit) begin
                rx_valid_q <= 1'b0;
            end
            if (commit) begin
                if (!rx_valid_q || rx_ready) begin
                    rx_valid_q <= 1'b1;
                    rx_data_q  <= shift_q;
                    perr_out_q <= perr_q;
                    ferr_out_q <= stop_ferr;
                    brk_out_q  <= stop_brk;
                end else begin
                    overrun_q <= 1'b1;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (fall) begin
                        prescale_q <= prescale;
                        nbits_q    <= data_bits(data_length, DATA_WIDTH);
                        par_en_q   <= parity_enable;
                        par_type_q <= parity_type;
                        stop2_q    <= stop_bits;
                        shift_q    <= '0;
                        idx_q      <= '0;
                        par_acc_q  <= 1'b0;
                        zero_q     <= 1'b1;
                        stop_idx_q <= 1'b0;
                        perr_q     <= 1'b0;
                        ferr_q     <= 1'b0;
                        brk_q      <= 1'b0;
                        state_q    <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_done && samp_bit) begin
                        state_q <= ST_IDLE;
                    end else if (wrap) begin
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        shift_q   <= shift_d;
                        par_acc_q <= par_acc_q ^ samp_bit;
                        if (samp_bit) begin
                            zero_q <= 1'b0;
                        end
                        if (idx_q == nbits_q - 4'd1) begin
                            idx_q   <= '0;
                            state_q <= par_en_q ? ST_PARITY : ST_STOP;
                        end else begin
                            idx_q <= idx_q + 4'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_done) begin
                        perr_q <= (par_acc_q ^ samp_bit) != (par_type_q == PARITY_ODD);
                        if (samp_bit) begin
                            zero_q <= 1'b0;
                        end
                        state_q <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_done) begin
                        ferr_q     <= stop_ferr;
                        brk_q      <= stop_brk;
                        stop_idx_q <= 1'b1;
                        if (commit) begin
                            state_q <= stop_brk ? ST_BREAK_WAIT : ST_IDLE;
                        end
                    end
                end
                ST_BREAK_WAIT: begin
                    if (line) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rx_valid      = rx_valid_q;
    assign rx_data       = rx_data_q;
    assign parity_error  = perr_out_q;
    assign frame_error   = ferr_out_q;
    assign break_detect  = brk_out_q;
    assign overrun_error = overrun_q;

endmodule

// File: tb/tb_uart_rx_ext.sv
// Bench for uart_rx_ext: serial frames built from a frame description, with
// expected status computed from the frame contents.
module tb_uart_rx_ext;

    localparam int DW = 8;
    localparam int PW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          serial_data_in;
    logic [PW-1:0] prescale;
    logic [1:0]    data_length;
    logic          parity_enable, parity_type, stop_bits, rx_ready;
    logic          rx_valid;
    logic [DW-1:0] rx_data;
    logic          parity_error, frame_error, break_detect, overrun_error;

    always #5 clk = ~clk;

    uart_rx_ext #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
        .clk            (clk),
        .reset          (reset),
        .serial_data_in (serial_data_in),
        .prescale       (prescale),
        .data_length    (data_length),
        .parity_enable  (parity_enable),
        .parity_type    (parity_type),
        .stop_bits      (stop_bits),
        .rx_ready       (rx_ready),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .parity_error   (parity_error),
        .frame_error    (frame_error),
        .break_detect   (break_detect),
        .overrun_error  (overrun_error)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          perr;
        logic          ferr;
        logic          brk;
    } rec_t;

    typedef struct {
        int         ps;
        logic [1:0] dlen;
        logic       pen, ptype, stop2;
        logic [8:0] data;
        logic       bad_par, s0, s1, glitch;
        int         gap;
    } frame_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    rec_t got_q[$];
    int   ovr_cnt = 0;
    int   valid_cycles = 0;

    // Observer: records every accepted word and counts overrun pulses
    always @(negedge clk) begin
        if (!reset) begin
            if (rx_valid) valid_cycles++;
            if (rx_valid && rx_ready) begin
                rec_t r;
                r.data = rx_data;
                r.perr = parity_error;
                r.ferr = frame_error;
                r.brk  = break_detect;
                got_q.push_back(r);
            end
            if (overrun_error) ovr_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int nbits(input frame_t f);
        int n = int'(f.dlen) + 5;
        return (n > DW) ? DW : n;
    endfunction

    function automatic int ones(input frame_t f);
        int c = 0;
        for (int i = 0; i < nbits(f); i++) c += int'(f.data[i]);
        return c;
    endfunction

    // Parity bit placed on the wire: makes the total count of ones even
    // (even parity) or odd (odd parity), inverted when a bad parity is wanted.
    function automatic logic wire_par(input frame_t f);
        int want = f.ptype ? 1 : 0;
        logic p = ((ones(f) % 2) != want);
        return p ^ f.bad_par;
    endfunction

    function automatic rec_t model(input frame_t f);
        rec_t e;
        int   n = nbits(f);
        int   d = 0;
        logic pb = wire_par(f);
        for (int i = 0; i < n; i++) d += int'(f.data[i]) << i;
        e.data = DW'(d);
        e.perr = f.pen && (((ones(f) + int'(pb)) % 2) != int'(f.ptype));
        e.ferr = !f.s0 || (f.stop2 && !f.s1);
        e.brk  = (d == 0) && (!f.pen || !pb) && !f.s0;
        return e;
    endfunction

    task automatic drive_bit(input logic b, input int ps, input logic glitch);
        for (int j = 0; j < ps; j++) begin
            serial_data_in = (glitch && j == ps / 2 + 1) ? ~b : b;
            tick();
        end
    endtask

    task automatic send_frame(input frame_t f);
        prescale      = PW'(f.ps);
        data_length   = f.dlen;
        parity_enable = f.pen;
        parity_type   = f.ptype;
        stop_bits     = f.stop2;
        drive_bit(1'b0, f.ps, 1'b0);
        for (int i = 0; i < nbits(f); i++) drive_bit(f.data[i], f.ps, f.glitch);
        if (f.pen) drive_bit(wire_par(f), f.ps, 1'b0);
        drive_bit(f.s0, f.ps, 1'b0);
        if (f.stop2) drive_bit(f.s1, f.ps, 1'b0);
        for (int i = 0; i < f.gap; i++) drive_bit(1'b1, f.ps, 1'b0);
    endtask

    function automatic frame_t f8n1(input int ps, input logic [8:0] d);
        frame_t f;
        f.ps = ps; f.dlen = 2'b11; f.pen = 1'b0; f.ptype = 1'b0; f.stop2 = 1'b0;
        f.data = d; f.bad_par = 1'b0; f.s0 = 1'b1; f.s1 = 1'b1; f.glitch = 1'b0; f.gap = 2;
        return f;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        serial_data_in = 1'b1;
        rx_ready = 1'b1;
        repeat (4) tick();
        n_cmp++;
        if ({rx_valid, rx_data, parity_error, frame_error, break_detect, overrun_error} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got valid=%b data=%h pe=%b fe=%b brk=%b ovr=%b, expected all 0",
                     rx_valid, rx_data, parity_error, frame_error, break_detect, overrun_error);
        end
        reset = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_basic();
        frame_t f = f8n1(16, 9'h0A5);
        rec_t   e = model(f);
        got_q.delete(); valid_cycles = 0;
        send_frame(f);
        n_cmp++;
        if (got_q.size() != 1) begin
            n_bad++; $display("FAIL basic_count: got %0d words, expected 1", got_q.size());
        end else begin
            rec_t r = got_q.pop_front();
            n_cmp++;
            if (r !== e) begin n_bad++; $display("FAIL basic_word: got %h, expected %h", r, e); end
        end
        n_cmp++;
        if (valid_cycles != 1) begin
            n_bad++; $display("FAIL basic_pulse: rx_valid high %0d cycles, expected 1", valid_cycles);
        end
    endtask

    task automatic test_parity();
        frame_t f = f8n1(8, 9'h055);
        rec_t   e;
        f.dlen = 2'b10; f.pen = 1'b1; f.ptype = 1'b1; f.stop2 = 1'b1; f.bad_par = 1'b1;
        e = model(f);
        got_q.delete();
        send_frame(f);
        n_cmp++;
        if (got_q.size() != 1) begin
            n_bad++; $display("FAIL parity_count: got %0d words, expected 1", got_q.size());
        end else begin
            rec_t r = got_q.pop_front();
            n_cmp++;
            if (r !== e) begin n_bad++; $display("FAIL parity_word: got %h, expected %h", r, e); end
        end
    endtask

    task automatic test_frame_break();
        frame_t f = f8n1(16, 9'h03C);
        rec_t   e;
        f.s0 = 1'b0;
        e = model(f);
        got_q.delete();
        send_frame(f);
        n_cmp++;
        if (got_q.size() != 1) begin
            n_bad++; $display("FAIL ferr_count: got %0d words, expected 1", got_q.size());
        end else begin
            rec_t r = got_q.pop_front();
            n_cmp++;
            if (r !== e) begin n_bad++; $display("FAIL ferr_word: got %h, expected %h", r, e); end
        end
        f = f8n1(16, 9'h000);
        f.s0 = 1'b0; f.gap = 0;
        e = model(f);
        send_frame(f);
        repeat (40) drive_bit(1'b0, 16, 1'b0);
        n_cmp++;
        if (got_q.size() != 1) begin
            n_bad++; $display("FAIL break_count: got %0d words during long low, expected 1", got_q.size());
        end else begin
            rec_t r = got_q.pop_front();
            n_cmp++;
            if (r !== e) begin n_bad++; $display("FAIL break_word: got %h, expected %h", r, e); end
        end
        repeat (2) drive_bit(1'b1, 16, 1'b0);
        f = f8n1(16, 9'h05A);
        e = model(f);
        send_frame(f);
        n_cmp++;
        if (got_q.size() != 1) begin
            n_bad++; $display("FAIL after_break_count: got %0d words, expected 1", got_q.size());
        end else begin
            rec_t r = got_q.pop_front();
            n_cmp++;
            if (r !== e) begin n_bad++; $display("FAIL after_break_word: got %h, expected %h", r, e); end
        end
    endtask

    task automatic test_overrun();
        got_q.delete(); ovr_cnt = 0;
        rx_ready = 1'b0;
        send_frame(f8n1(16, 9'h011));
        send_frame(f8n1(16, 9'h022));
        n_cmp++;
        if (!(rx_valid === 1'b1 && rx_data === DW'(8'h11))) begin
            n_bad++; $display("FAIL overrun_hold: got valid=%b data=%h, expected valid=1 data=11", rx_valid, rx_data);
        end
        n_cmp++;
        if (ovr_cnt != 1) begin
            n_bad++; $display("FAIL overrun_pulse: got %0d pulses, expected 1", ovr_cnt);
        end
        rx_ready = 1'b1;
        tick(); tick();
        n_cmp++;
        if (rx_valid !== 1'b0) begin
            n_bad++; $display("FAIL overrun_drain: rx_valid=%b after accept, expected 0", rx_valid);
        end
        n_cmp++;
        if (got_q.size() != 1 || got_q[0].data !== DW'(8'h11)) begin
            n_bad++; $display("FAIL overrun_accept: got %0d words (first %h), expected one word 11",
                              got_q.size(), (got_q.size() > 0) ? got_q[0].data : '0);
        end
        got_q.delete();
    endtask

    task automatic test_glitch();
        frame_t f;
        rec_t   e;
        got_q.delete(); valid_cycles = 0;
        prescale = PW'(16);
        serial_data_in = 1'b0;
        repeat (3) tick();
        serial_data_in = 1'b1;
        repeat (48) tick();
        n_cmp++;
        if (valid_cycles != 0) begin
            n_bad++; $display("FAIL glitch_reject: rx_valid high %0d cycles, expected 0", valid_cycles);
        end
        f = f8n1(16, 9'($urandom_range(0, 255)));
        f.glitch = 1'b1;
        e = model(f);
        send_frame(f);
        n_cmp++;
        if (got_q.size() != 1) begin
            n_bad++; $display("FAIL majority_count: got %0d words, expected 1", got_q.size());
        end else begin
            rec_t r = got_q.pop_front();
            n_cmp++;
            if (r !== e) begin n_bad++; $display("FAIL majority_word: got %h, expected %h", r, e); end
        end
    endtask

    task automatic test_reset_mid();
        frame_t f;
        rec_t   e;
        got_q.delete(); valid_cycles = 0;
        prescale = PW'(16); data_length = 2'b11; parity_enable = 1'b0; stop_bits = 1'b0;
        drive_bit(1'b0, 16, 1'b0);
        drive_bit(1'b1, 16, 1'b0);
        serial_data_in = 1'b0;
        repeat (8) tick();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (16 * 12) tick();
        n_cmp++;
        if (valid_cycles != 0) begin
            n_bad++; $display("FAIL reset_abort: rx_valid high %0d cycles, expected 0", valid_cycles);
        end
        repeat (2) drive_bit(1'b1, 16, 1'b0);
        f = f8n1(16, 9'h081);
        e = model(f);
        send_frame(f);
        n_cmp++;
        if (got_q.size() != 1) begin
            n_bad++; $display("FAIL reset_next_count: got %0d words, expected 1", got_q.size());
        end else begin
            rec_t r = got_q.pop_front();
            n_cmp++;
            if (r !== e) begin n_bad++; $display("FAIL reset_next_word: got %h, expected %h", r, e); end
        end
    endtask

    task automatic test_back_to_back();
        rec_t exp_q[$];
        got_q.delete();
        for (int i = 0; i < 4; i++) begin
            frame_t f = f8n1(16, 9'($urandom_range(0, 255)));
            f.gap = (i == 3) ? 2 : 0;
            exp_q.push_back(model(f));
            send_frame(f);
        end
        n_cmp++;
        if (got_q.size() != 4) begin
            n_bad++; $display("FAIL b2b_count: got %0d words, expected 4", got_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (got_q[i] !== exp_q[i]) begin
                    n_bad++; $display("FAIL b2b_word%0d: got %h, expected %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        got_q.delete();
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            frame_t f;
            rec_t   e;
            f.ps      = 2 * int'($urandom_range(4, 16));
            f.dlen    = 2'($urandom_range(0, 3));
            f.pen     = 1'($urandom_range(0, 1));
            f.ptype   = 1'($urandom_range(0, 1));
            f.stop2   = 1'($urandom_range(0, 1));
            f.data    = ($urandom_range(0, 5) == 0) ? 9'h000 : 9'($urandom);
            f.bad_par = 1'($urandom_range(0, 1));
            f.s0      = ($urandom_range(0, 5) != 0);
            f.s1      = ($urandom_range(0, 5) != 0);
            f.glitch  = 1'($urandom_range(0, 1));
            f.gap     = 2;
            e = model(f);
            got_q.delete();
            send_frame(f);
            n_cmp++;
            if (got_q.size() != 1) begin
                n_bad++; $display("FAIL rand%0d_count: got %0d words, expected 1", i, got_q.size());
            end else begin
                rec_t r = got_q.pop_front();
                n_cmp++;
                if (r !== e) begin
                    n_bad++;
                    $display("FAIL rand%0d_word: got %h, expected %h (ps=%0d dlen=%0d pen=%b pt=%b st2=%b)",
                             i, r, e, f.ps, f.dlen, f.pen, f.ptype, f.stop2);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        serial_data_in = 1'b1;
        prescale = PW'(16);
        data_length = 2'b11;
        parity_enable = 1'b0;
        parity_type = 1'b0;
        stop_bits = 1'b0;
        rx_ready = 1'b1;
        test_reset();
        test_basic();
        test_parity();
        test_frame_break();
        test_overrun();
        test_glitch();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
